// File: rtl/lsu_axi_rd_responder_pkg.sv
// lsu_axi_pkg: shared response/burst codes, FSM states and beat record for the LSU read responder.
`default_nettype none

package lsu_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_8B     = 3'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic [7:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } rd_beat_t;

endpackage

`default_nettype wire

// File: rtl/lsu_axi_rd_responder_if.sv
// lsu_axi_rd_responder_if: AR request and R beat channels between the LSU read initiator and the responder.
`default_nettype none

interface lsu_axi_rd_responder_if;

  logic [7:0]  lsu_axi_arid;
  logic [9:0]  lsu_axi_araddr;
  logic [7:0]  lsu_axi_arlen;
  logic [2:0]  lsu_axi_arsize;
  logic [1:0]  lsu_axi_arburst;
  logic [2:0]  lsu_axi_arstr;
  logic [7:0]  lsu_axi_arnum;
  logic        lsu_axi_arvld;
  logic        axi_lsu_arrdy;
  logic [7:0]  axi_lsu_rid;
  logic [63:0] axi_lsu_rdata;
  logic [1:0]  axi_lsu_rresp;
  logic        axi_lsu_rlast;
  logic        axi_lsu_rvld;
  logic        lsu_axi_rrdy;

  modport master (
    output lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize,
           lsu_axi_arburst, lsu_axi_arstr, lsu_axi_arnum, lsu_axi_arvld, lsu_axi_rrdy,
    input  axi_lsu_arrdy, axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp, axi_lsu_rlast, axi_lsu_rvld
  );

  modport slave (
    input  lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize,
           lsu_axi_arburst, lsu_axi_arstr, lsu_axi_arnum, lsu_axi_arvld, lsu_axi_rrdy,
    output axi_lsu_arrdy, axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp, axi_lsu_rlast, axi_lsu_rvld
  );

endinterface

`default_nettype wire

// File: rtl/lsu_axi_rd_responder_skid_fifo.sv
// axi_rd_skid_fifo: 2-entry beat FIFO absorbing the read pipeline while R is backpressured.
`default_nettype none

module axi_rd_skid_fifo
  import lsu_axi_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  rd_beat_t push_data_i,
  input  logic     pop_i,
  output rd_beat_t head_o,
  output logic [1:0] count_o
);

  rd_beat_t   mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/lsu_axi_rd_responder.sv
// lsu_axi_rd_responder: walks a strided multi-segment read burst over a sync-read word memory and returns R beats.
`default_nettype none

module lsu_axi_rd_responder
  import lsu_axi_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  lsu_axi_rd_responder_if.slave axi,
  output logic                  mem_rd_en,
  output logic [9:0]            mem_rd_addr,
  input  logic [DATA_W-1:0]     mem_rd_data
);

  rd_state_e  state_q, state_d;
  logic [7:0] id_q, id_d;
  logic [7:0] len_q, len_d;
  logic [2:0] str_q, str_d;
  logic [7:0] num_q, num_d;
  logic       err_q, err_d;
  logic [9:0] base_q, base_d;
  logic [7:0] beat_q, beat_d;
  logic [7:0] seg_q, seg_d;
  logic       arrdy_q, arrdy_d;
  logic       pv_q, pv_d;
  logic       pr_q, pr_d;
  logic [1:0] presp_q, presp_d;
  logic       plast_q, plast_d;

  logic [9:0] w_addr;
  logic [9:0] w_stride;
  logic [1:0] w_resp;
  logic       w_oob, w_last, w_credit, w_issue, w_ar_hs;
  logic       w_empty, w_rvld, w_pop, w_push, w_final_hs;
  logic [1:0] w_fifo_cnt;
  rd_beat_t   w_pipe, w_head, w_fifo_head;

  assign w_addr   = base_q + {2'd0, beat_q};
  assign w_stride = ({2'd0, len_q} + 10'd1) << str_q;
  assign w_oob    = 32'(w_addr) >= 32'(DEPTH);
  assign w_resp   = err_q ? RESP_SLVERR : (w_oob ? RESP_DECERR : RESP_OKAY);
  assign w_last   = (beat_q == len_q) && (seg_q == num_q);
  // Storage is FIFO plus the one beat in the memory pipeline; never issue past it.
  assign w_credit = ({1'b0, w_fifo_cnt} + {2'd0, pv_q}) <= 3'd1;
  assign w_issue  = (state_q == ISSUE) && w_credit;
  assign w_ar_hs  = (state_q == IDLE) && axi.lsu_axi_arvld && arrdy_q;

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    len_d       = len_q;
    str_d       = str_q;
    num_d       = num_q;
    err_d       = err_q;
    base_d      = base_q;
    beat_d      = beat_q;
    seg_d       = seg_q;
    pv_d        = w_issue;
    pr_d        = w_issue && (w_resp == RESP_OKAY);
    presp_d     = w_resp;
    plast_d     = w_last;
    mem_rd_en   = 1'b0;
    mem_rd_addr = w_addr;
    case (state_q)
      IDLE: begin
        if (w_ar_hs) begin
          state_d = ISSUE;
          id_d    = axi.lsu_axi_arid;
          len_d   = axi.lsu_axi_arlen;
          str_d   = axi.lsu_axi_arstr;
          num_d   = axi.lsu_axi_arnum;
          err_d   = (axi.lsu_axi_arburst != BURST_INCR) || (axi.lsu_axi_arsize != SIZE_8B);
          base_d  = axi.lsu_axi_araddr;
          beat_d  = 8'd0;
          seg_d   = 8'd0;
        end
      end
      ISSUE: begin
        if (w_issue) begin
          mem_rd_en = (w_resp == RESP_OKAY);
          if (beat_q == len_q) begin
            beat_d = 8'd0;
            seg_d  = seg_q + 8'd1;
            base_d = base_q + w_stride;
          end else begin
            beat_d = beat_q + 8'd1;
          end
          if (w_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (w_final_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    arrdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= 8'd0;
      len_q   <= 8'd0;
      str_q   <= 3'd0;
      num_q   <= 8'd0;
      err_q   <= 1'b0;
      base_q  <= 10'd0;
      beat_q  <= 8'd0;
      seg_q   <= 8'd0;
      arrdy_q <= 1'b0;
      pv_q    <= 1'b0;
      pr_q    <= 1'b0;
      presp_q <= 2'd0;
      plast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      len_q   <= len_d;
      str_q   <= str_d;
      num_q   <= num_d;
      err_q   <= err_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      seg_q   <= seg_d;
      arrdy_q <= arrdy_d;
      pv_q    <= pv_d;
      pr_q    <= pr_d;
      presp_q <= presp_d;
      plast_q <= plast_d;
    end
  end

  // Memory data is only valid the cycle after the read, so an empty FIFO is bypassed
  // and a beat that is not accepted immediately is parked in the FIFO.
  assign w_pipe     = '{id: id_q, data: (pr_q ? mem_rd_data : 64'd0), resp: presp_q, last: plast_q};
  assign w_empty    = (w_fifo_cnt == 2'd0);
  assign w_rvld     = !w_empty || pv_q;
  assign w_head     = !w_empty ? w_fifo_head : (pv_q ? w_pipe : '0);
  assign w_pop      = !w_empty && axi.lsu_axi_rrdy;
  assign w_push     = pv_q && !(w_empty && axi.lsu_axi_rrdy);
  assign w_final_hs = w_rvld && axi.lsu_axi_rrdy && w_head.last;

  axi_rd_skid_fifo u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (w_push),
    .push_data_i (w_pipe),
    .pop_i       (w_pop),
    .head_o      (w_fifo_head),
    .count_o     (w_fifo_cnt)
  );

  assign axi.axi_lsu_arrdy = arrdy_q;
  assign axi.axi_lsu_rvld  = w_rvld;
  assign axi.axi_lsu_rid   = w_head.id;
  assign axi.axi_lsu_rdata = w_head.data;
  assign axi.axi_lsu_rresp = w_head.resp;
  assign axi.axi_lsu_rlast = w_head.last;

endmodule

`default_nettype wire

// File: tb/tb_lsu_axi_rd_responder.sv
// tb_lsu_axi_rd_responder: two responders (DEPTH 1024 and 512) driven in lockstep against a burst-list model.
`default_nettype none

module tb_lsu_axi_rd_responder;

  typedef struct {
    logic [7:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] ar_id = '0;
  logic [9:0] ar_addr = '0;
  logic [7:0] ar_len = '0, ar_num = '0;
  logic [2:0] ar_size = 3'd3, ar_str = '0;
  logic [1:0] ar_burst = 2'b01;
  logic       ar_vld = 1'b0;
  logic       rrdy = 1'b1;
  int         rr_mode = 0;

  lsu_axi_rd_responder_if if0 ();
  lsu_axi_rd_responder_if if1 ();

  assign if0.lsu_axi_arid = ar_id;     assign if1.lsu_axi_arid = ar_id;
  assign if0.lsu_axi_araddr = ar_addr; assign if1.lsu_axi_araddr = ar_addr;
  assign if0.lsu_axi_arlen = ar_len;   assign if1.lsu_axi_arlen = ar_len;
  assign if0.lsu_axi_arsize = ar_size; assign if1.lsu_axi_arsize = ar_size;
  assign if0.lsu_axi_arburst = ar_burst; assign if1.lsu_axi_arburst = ar_burst;
  assign if0.lsu_axi_arstr = ar_str;   assign if1.lsu_axi_arstr = ar_str;
  assign if0.lsu_axi_arnum = ar_num;   assign if1.lsu_axi_arnum = ar_num;
  assign if0.lsu_axi_arvld = ar_vld;   assign if1.lsu_axi_arvld = ar_vld;
  assign if0.lsu_axi_rrdy = rrdy;      assign if1.lsu_axi_rrdy = rrdy;

  logic        men0, men1;
  logic [9:0]  maddr0, maddr1;
  logic [63:0] mdat0 = '0, mdat1 = '0;
  logic [63:0] mem [1024];

  always @(posedge clk) begin
    if (men0) mdat0 <= mem[maddr0];
    if (men1) mdat1 <= mem[maddr1];
  end

  lsu_axi_rd_responder #(.DEPTH(1024), .DATA_W(64)) dut0 (
    .clk(clk), .rst(rst), .axi(if0.slave),
    .mem_rd_en(men0), .mem_rd_addr(maddr0), .mem_rd_data(mdat0)
  );

  lsu_axi_rd_responder #(.DEPTH(512), .DATA_W(64)) dut1 (
    .clk(clk), .rst(rst), .axi(if1.slave),
    .mem_rd_en(men1), .mem_rd_addr(maddr1), .mem_rd_data(mdat1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  exp_t       expq [2][$];
  int         ok_cnt [2];
  int         mem_cnt [2];
  int         beats_done [2];
  int         first_vld [2];
  int         first_en [2];
  bit         seen_vld [2];
  bit         seen_en [2];
  bit         held [2];
  logic [74:0] hold_val [2];
  int         hs_cyc = 0;

  task automatic mon(input int k, input logic vld, input logic [7:0] id, input logic [63:0] data,
                     input logic [1:0] resp, input logic last, input logic en);
    exp_t e;
    if (en) begin
      mem_cnt[k]++;
      if (!seen_en[k]) begin seen_en[k] = 1'b1; first_en[k] = cyc; end
    end
    if (vld) begin
      if (!seen_vld[k]) begin seen_vld[k] = 1'b1; first_vld[k] = cyc; end
      if (held[k]) check($sformatf("i%0d_hold", k), {21'd0, id, data, resp, last}, {21'd0, hold_val[k]});
      if (rrdy) begin
        held[k] = 1'b0;
        if (expq[k].size() == 0) begin
          check($sformatf("i%0d_spurious_beat", k), 96'd1, 96'd0);
        end else begin
          e = expq[k].pop_front();
          beats_done[k]++;
          check($sformatf("i%0d_rid", k), {88'd0, id}, {88'd0, e.id});
          check($sformatf("i%0d_rdata", k), {32'd0, data}, {32'd0, e.data});
          check($sformatf("i%0d_rresp", k), {94'd0, resp}, {94'd0, e.resp});
          check($sformatf("i%0d_rlast", k), {95'd0, last}, {95'd0, e.last});
        end
      end else begin
        held[k] = 1'b1;
        hold_val[k] = {id, data, resp, last};
      end
    end else if (held[k]) begin
      check($sformatf("i%0d_rvld_dropped", k), 96'd0, 96'd1);
      held[k] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, if0.axi_lsu_rvld, if0.axi_lsu_rid, if0.axi_lsu_rdata, if0.axi_lsu_rresp, if0.axi_lsu_rlast, men0);
      mon(1, if1.axi_lsu_rvld, if1.axi_lsu_rid, if1.axi_lsu_rdata, if1.axi_lsu_rresp, if1.axi_lsu_rlast, men1);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 rrdy = (rr_mode != 0) ? 1'($urandom % 2) : 1'b1;
    end
  end

  // Expected beat list: segment s, beat b lands on araddr + s*((len+1)<<str) + b, modulo 1024.
  task automatic build(input logic [7:0] id, input int addr, input int len, input int str,
                       input int num, input bit bad);
    exp_t e;
    int a, depth;
    for (int k = 0; k < 2; k++) begin
      depth = (k == 0) ? 1024 : 512;
      expq[k].delete();
      ok_cnt[k] = 0; mem_cnt[k] = 0; beats_done[k] = 0;
      seen_vld[k] = 1'b0; seen_en[k] = 1'b0; held[k] = 1'b0;
      for (int s = 0; s <= num; s++) begin
        for (int b = 0; b <= len; b++) begin
          a = (addr + s * ((len + 1) << str) + b) % 1024;
          e.id   = id;
          e.resp = bad ? 2'b10 : ((a >= depth) ? 2'b11 : 2'b00);
          e.data = (e.resp == 2'b00) ? mem[a] : 64'd0;
          e.last = (s == num) && (b == len);
          if (e.resp == 2'b00) ok_cnt[k]++;
          expq[k].push_back(e);
        end
      end
    end
  endtask

  task automatic send_ar(input logic [7:0] id, input int addr, input int len, input logic [1:0] burst,
                         input logic [2:0] size, input int str, input int num);
    bit got;
    build(id, addr, len, str, num, (burst != 2'b01) || (size != 3'd3));
    @(posedge clk);
    #1;
    ar_id = id; ar_addr = 10'(addr); ar_len = 8'(len); ar_burst = burst;
    ar_size = size; ar_str = 3'(str); ar_num = 8'(num); ar_vld = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (if0.axi_lsu_arrdy) begin got = 1'b1; break; end
    end
    check("ar_accept", {95'd0, got}, 96'd1);
    hs_cyc = cyc;
    @(posedge clk);
    #1 ar_vld = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (expq[0].size() == 0 && expq[1].size() == 0) begin done = 1'b1; break; end
    end
    check({tag, "_complete"}, {95'd0, done}, 96'd1);
    #1;
    check({tag, "_arrdy_back"}, {95'd0, if0.axi_lsu_arrdy}, 96'd1);
    check({tag, "_memrd0"}, 96'(mem_cnt[0]), 96'(ok_cnt[0]));
    check({tag, "_memrd1"}, 96'(mem_cnt[1]), 96'(ok_cnt[1]));
  endtask

  initial begin
    bit got;
    for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
    mem[10] = 64'hA5;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {if0.axi_lsu_arrdy, if0.axi_lsu_rvld, if0.axi_lsu_rlast, if0.axi_lsu_rid,
                            if0.axi_lsu_rdata, if0.axi_lsu_rresp, men0}, 96'd0);
    rst = 1'b0;
    @(posedge clk);
    #1 check("arrdy_after_reset", {95'd0, if0.axi_lsu_arrdy}, 96'd1);

    send_ar(8'h3C, 10, 0, 2'b01, 3'd3, 0, 0);
    wait_done("single");
    check("single_rvld_latency", 96'(first_vld[0] - hs_cyc), 96'd2);
    check("single_memrd_latency", 96'(first_en[0] - hs_cyc), 96'd1);

    send_ar(8'h11, 0, 1, 2'b01, 3'd3, 2, 2);
    wait_done("strided");

    rr_mode = 1;
    send_ar(8'h22, 100, 7, 2'b01, 3'd3, 0, 0);
    wait_done("backpressure");
    rr_mode = 0;

    send_ar(8'h33, 40, 3, 2'b10, 3'd3, 0, 0);
    wait_done("slverr");

    send_ar(8'h44, 510, 3, 2'b01, 3'd3, 0, 0);
    wait_done("decerr");

    send_ar(8'h55, 1022, 3, 2'b01, 3'd3, 0, 0);
    wait_done("wrap");

    rr_mode = 1;
    for (int t = 0; t < 8; t++) begin
      send_ar(8'($urandom), int'($urandom_range(0, 1023)), int'($urandom_range(0, 7)),
              ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b01,
              ($urandom_range(0, 4) == 0) ? 3'd2 : 3'd3,
              int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      wait_done("random");
    end
    rr_mode = 0;

    send_ar(8'h66, 200, 7, 2'b01, 3'd3, 0, 0);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (beats_done[0] >= 3) begin got = 1'b1; break; end
    end
    check("midrst_progress", {95'd0, got}, 96'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_rvld", {94'd0, if0.axi_lsu_rvld, if1.axi_lsu_rvld}, 96'd0);
    check("midrst_arrdy", {95'd0, if0.axi_lsu_arrdy}, 96'd0);
    for (int k = 0; k < 2; k++) begin expq[k].delete(); held[k] = 1'b0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("midrst_arrdy_low", {95'd0, if0.axi_lsu_arrdy}, 96'd0);
    @(posedge clk);
    #1 check("midrst_arrdy_release", {95'd0, if0.axi_lsu_arrdy}, 96'd1);
    repeat (4) @(posedge clk);
    send_ar(8'h77, 300, 2, 2'b01, 3'd3, 1, 1);
    wait_done("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
